// File: rtl/bit_filling_if.sv
// Request/result bundle for bit_filling: the master issues start/count/offset,
// the filler returns the generated word with busy/done/err status.
interface bit_filling_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1),
  parameter int OW    = $clog2(WIDTH)
);
  // Handshake: start is a level request seen only while the filler is idle;
  // done stays high until start is observed low, so a held start never retriggers.
  logic             start;
  logic [CW-1:0]    count;
  logic [OW-1:0]    offset;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, count, offset,
    input  data, busy, done, err
  );

  modport slave (
    input  start, count, offset,
    output data, busy, done, err
  );
endinterface

// File: rtl/bit_filling.sv
// Builds a WIDTH-bit word holding K ones at contiguous positions starting at P,
// one bit per clock, wrapping modulo WIDTH. Counts above WIDTH clamp and flag err.
module bit_filling #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1),
  parameter int OW    = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         reset,
  bit_filling_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [OW-1:0]    pos;
  logic [CW-1:0]    rem;
  logic [WIDTH-1:0] data_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             cnt_over;
  logic [CW-1:0]    cnt_clamped;
  logic             off_in_range;
  logic [OW-1:0]    pos_next;

  always_comb begin
    cnt_over     = (int'(bus.count) > WIDTH);
    cnt_clamped  = cnt_over ? CW'(WIDTH) : bus.count;
    off_in_range = (int'(bus.offset) < WIDTH);
    pos_next     = (pos == OW'(WIDTH - 1)) ? '0 : pos + OW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      pos    <= '0;
      rem    <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            data_q <= '0;
            pos    <= off_in_range ? bus.offset : '0;
            rem    <= cnt_clamped;
            err_q  <= cnt_over;
            if (cnt_clamped == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state  <= S_FILL;
              busy_q <= 1'b1;
            end
          end
        end
        S_FILL: begin
          // Clamped K never exceeds WIDTH, so no position is visited twice.
          data_q[pos] <= 1'b1;
          pos         <= pos_next;
          rem         <= rem - CW'(1);
          if (rem == CW'(1)) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (!bus.start) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data  = data_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_bit_filling.sv
// Directed bench for bit_filling (WIDTH=8): fills, wrap-around, clamping,
// asynchronous reset mid-fill, and a popcount loopback sweep.
module tb_bit_filling;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int OW    = $clog2(WIDTH);

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [WIDTH-1:0] exp_q[$];

  bit_filling_if #(.WIDTH(WIDTH)) bus ();

  bit_filling #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock/reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      checks_passed++;
  endtask

  function automatic int popc(input logic [WIDTH-1:0] v);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] fill_model(input int k, input int off);
    logic [WIDTH-1:0] w = '0;
    int kk = (k > WIDTH) ? WIDTH : k;
    for (int i = 0; i < kk; i++) w[(off + i) % WIDTH] = 1'b1;
    return w;
  endfunction

  // Drivers: all inputs change 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int k, input int off);
    bus.count  = CW'(k);
    bus.offset = OW'(off);
    bus.start  = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string tag, output int busy_n);
    busy_n = 0;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      if (bus.busy) busy_n++;
      tick();
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
  endtask

  task automatic release_start();
    bus.start = 1'b0;
    tick();
  endtask

  initial begin
    int busy_n;
    logic [WIDTH-1:0] exp_w;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.count  = '0;
    bus.offset = '0;
    #12;
    check("rst_data",  32'(bus.data), 32'h0);
    check("rst_busy",  32'(bus.busy), 32'h0);
    check("rst_done",  32'(bus.done), 32'h0);
    check("rst_err",   32'(bus.err),  32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    reset = 1'b0;
    tick();

    // 1: K=3 at P=0, then hold start in S_DONE
    do_load(3, 0);
    wait_done("t1", busy_n);
    check("t1_busy_cycles", 32'(busy_n), 32'd3);
    check("t1_data", 32'(bus.data), 32'h07);
    check("t1_err",  32'(bus.err),  32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("t1_hold_done", 32'(bus.done), 32'h1);
    check("t1_hold_data", 32'(bus.data), 32'h07);
    release_start();
    check("t1_idle_done", 32'(bus.done), 32'h0);
    check("t1_idle_data", 32'(bus.data), 32'h07);

    // 2: wrap-around, bits 6,7,0,1
    do_load(4, 6);
    wait_done("t2", busy_n);
    check("t2_busy_cycles", 32'(busy_n), 32'd4);
    check("t2_data", 32'(bus.data), 32'hC3);
    release_start();

    // 3: K=0 finishes right at the load edge
    do_load(0, 3);
    check("t3_done_now", 32'(bus.done), 32'h1);
    check("t3_busy", 32'(bus.busy), 32'h0);
    check("t3_data", 32'(bus.data), 32'h00);
    release_start();

    // 4: full word, clamped count, then err cleared by a normal load
    do_load(8, 5);
    wait_done("t4a", busy_n);
    check("t4a_busy_cycles", 32'(busy_n), 32'd8);
    check("t4a_data", 32'(bus.data), 32'hFF);
    check("t4a_err",  32'(bus.err),  32'h0);
    release_start();
    do_load(12, 0);
    check("t4b_err_at_load", 32'(bus.err), 32'h1);
    wait_done("t4b", busy_n);
    check("t4b_busy_cycles", 32'(busy_n), 32'd8);
    check("t4b_data", 32'(bus.data), 32'hFF);
    check("t4b_err",  32'(bus.err),  32'h1);
    release_start();
    do_load(1, 4);
    check("t4c_err", 32'(bus.err), 32'h0);
    wait_done("t4c", busy_n);
    check("t4c_data", 32'(bus.data), 32'h10);
    release_start();

    // 5: asynchronous reset between edges after two fill cycles
    do_load(5, 0);
    tick();
    tick();
    check("t5_partial", 32'(bus.data), 32'h03);
    #3 reset = 1'b1;
    #1;
    check("t5_async_data", 32'(bus.data), 32'h0);
    check("t5_async_busy", 32'(bus.busy), 32'h0);
    check("t5_async_done", 32'(bus.done), 32'h0);
    tick();
    check("t5_rst_beats_start", 32'(state_dbg), 32'h0);
    bus.start = 1'b0;
    #2 reset = 1'b0;
    tick();
    tick();
    check("t5_stay_idle", 32'(state_dbg), 32'h0);
    check("t5_idle_busy", 32'(bus.busy), 32'h0);

    // 6: loopback sweep, popcount must equal K; word checked against model
    for (int k = 0; k <= WIDTH; k++) begin
      exp_q.push_back(WIDTH'(k));
      do_load(k, 2);
      wait_done("t6", busy_n);
      check("t6_popcount", 32'(popc(bus.data)), 32'(exp_q.pop_front()));
      exp_w = fill_model(k, 2);
      check("t6_word", 32'(bus.data), 32'(exp_w));
      release_start();
    end

    // 6b: inputs changed and start dropped mid-fill must not disturb the result
    do_load(5, 1);
    tick();
    bus.count  = CW'(2);
    bus.offset = OW'(7);
    bus.start  = 1'b0;
    wait_done("t6b", busy_n);
    check("t6b_data", 32'(bus.data), 32'h3E);
    check("t6b_popcount", 32'(popc(bus.data)), 32'd5);
    tick();
    check("t6b_back_idle", 32'(state_dbg), 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
